// File: rtl/rst_seq_pkg.sv
// Shared FSM state encoding and default timing constants for the rst_seq reset sequencer.
package rst_seq_pkg;

   typedef enum logic [2:0] {
      ST_POR,
      ST_HOLD,
      ST_RDY_WAIT,
      ST_RELEASE,
      ST_RUN
   } state_t;

   localparam int unsigned DEF_N_CH      = 4;
   localparam int unsigned DEF_CNT_W     = 28;
   localparam int unsigned DEF_T_POR     = 8100000;
   localparam int unsigned DEF_T_STEP    = 1000;
   localparam int unsigned DEF_T_SOFT    = 1000;
   localparam int unsigned DEF_RDY_FILT  = 16;
   localparam int unsigned DEF_T_RDY_TMO = 2700000;

   localparam logic [7:0] LOST_MAX = 8'd255;

endpackage

// File: rtl/rst_seq_rdy_filt.sv
// Ready qualifier: counts consecutive rdy_i highs, clears synchronously, pulses qual_o on the
// edge where the run length reaches RDY_FILT.
module rdy_filt #(
   parameter int unsigned RDY_FILT = 16
) (
   input  logic clk,
   input  logic rst_i,
   input  logic clr_i,
   input  logic rdy_i,
   output logic qual_o
);

   localparam int unsigned    FW   = $clog2(RDY_FILT + 1);
   localparam logic [FW-1:0]  LAST = FW'(RDY_FILT - 1);
   localparam logic [FW-1:0]  FULL = FW'(RDY_FILT);

   logic [FW-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (!rst_i || clr_i || !rdy_i) begin
         cnt_q <= '0;
      end else if (cnt_q != FULL) begin
         cnt_q <= cnt_q + FW'(1);
      end
   end

   assign qual_o = !clr_i && rdy_i && (cnt_q == LAST);

endmodule

// File: rtl/rst_seq.sv
// Multi-channel reset sequencer: POR hold, ready qualification, staggered release, soft/loss re-assert.
// Optional ready-wait timeout enabled by defining RST_SEQ_RDY_TMO_EN.
module rst_seq
   import rst_seq_pkg::*;
#(
   parameter int unsigned N_CH      = DEF_N_CH,
   parameter int unsigned CNT_W     = DEF_CNT_W,
   parameter int unsigned T_POR     = DEF_T_POR,
   parameter int unsigned T_STEP    = DEF_T_STEP,
   parameter int unsigned T_SOFT    = DEF_T_SOFT,
   parameter int unsigned RDY_FILT  = DEF_RDY_FILT,
   parameter int unsigned T_RDY_TMO = DEF_T_RDY_TMO
) (
   input  logic            clk,
   input  logic            rst_i,
   input  logic            soft_rst_i,
   input  logic            rdy_i,
   output logic [N_CH-1:0] rst_o,
   output logic            done_o,
   output logic [7:0]      lost_cnt_o,
   output logic            tmo_o,
   output logic            rdy_err_o
);

   localparam int unsigned       STG_W     = $clog2(N_CH + 1);
   localparam logic [CNT_W-1:0]  POR_LAST  = CNT_W'(T_POR - 1);
   localparam logic [CNT_W-1:0]  STEP_LAST = CNT_W'(T_STEP - 1);
   localparam logic [CNT_W-1:0]  SOFT_LAST = CNT_W'(T_SOFT - 1);
   localparam logic [STG_W-1:0]  STG_LAST  = STG_W'(N_CH - 1);

   if (N_CH < 1 || T_POR < 1 || T_STEP < 1 || T_SOFT < 1 || RDY_FILT < 1 || T_RDY_TMO < 1)
   begin : g_cfg_err
      $error("rst_seq: invalid timing parameters");
   end

   state_t           state_q;
   logic [CNT_W-1:0] timer_q;
   logic [STG_W-1:0] stage_q;
   logic [N_CH-1:0]  rst_q;
   logic             done_q;
   logic [7:0]       lost_q;
   logic [7:0]       lost_d;
   logic             qual;
   logic             loss;

   rdy_filt #(.RDY_FILT(RDY_FILT)) u_filt (
      .clk    (clk),
      .rst_i  (rst_i),
      .clr_i  (state_q != ST_RDY_WAIT),
      .rdy_i  (rdy_i),
      .qual_o (qual)
   );

   assign loss = !rdy_i && (state_q == ST_RELEASE || state_q == ST_RUN);

   always_comb begin
      lost_d = lost_q;
      if (lost_q != LOST_MAX) lost_d = lost_q + 8'd1;
   end

`ifdef RST_SEQ_RDY_TMO_EN
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(T_RDY_TMO - 1);
   logic [CNT_W-1:0] wtmr_q;
   logic             tmo_q;
   logic             err_q;
   assign tmo_o     = tmo_q;
   assign rdy_err_o = err_q;
`else
   assign tmo_o     = 1'b0;
   assign rdy_err_o = 1'b0;
`endif

   // Channels release lowest-first, so each release is a left shift of the all-ones mask.
   always_ff @(posedge clk) begin
      if (!rst_i) begin
         state_q <= ST_POR;
         timer_q <= '0;
         stage_q <= '0;
         rst_q   <= '1;
         done_q  <= 1'b0;
         lost_q  <= '0;
`ifdef RST_SEQ_RDY_TMO_EN
         wtmr_q  <= '0;
         tmo_q   <= 1'b0;
         err_q   <= 1'b0;
`endif
      end else begin
`ifdef RST_SEQ_RDY_TMO_EN
         tmo_q  <= 1'b0;
         wtmr_q <= '0;
`endif
         if (soft_rst_i) begin
            state_q <= ST_HOLD;
            timer_q <= '0;
            stage_q <= '0;
            rst_q   <= '1;
            done_q  <= 1'b0;
         end else if (loss) begin
            state_q <= ST_RDY_WAIT;
            timer_q <= '0;
            stage_q <= '0;
            rst_q   <= '1;
            done_q  <= 1'b0;
            lost_q  <= lost_d;
         end else begin
            case (state_q)
               ST_POR: begin
                  if (timer_q == POR_LAST) begin
                     timer_q <= '0;
                     state_q <= ST_RDY_WAIT;
                  end else begin
                     timer_q <= timer_q + CNT_W'(1);
                  end
               end
               ST_HOLD: begin
                  if (timer_q == SOFT_LAST) begin
                     timer_q <= '0;
                     state_q <= ST_RDY_WAIT;
                  end else begin
                     timer_q <= timer_q + CNT_W'(1);
                  end
               end
               ST_RDY_WAIT: begin
                  if (qual) begin
                     rst_q   <= rst_q << 1;
                     timer_q <= '0;
                     if (N_CH == 1) begin
                        done_q  <= 1'b1;
                        state_q <= ST_RUN;
                     end else begin
                        stage_q <= STG_W'(1);
                        state_q <= ST_RELEASE;
                     end
                  end else begin
`ifdef RST_SEQ_RDY_TMO_EN
                     if (wtmr_q == TMO_LAST) begin
                        tmo_q   <= 1'b1;
                        err_q   <= 1'b1;
                        timer_q <= '0;
                        state_q <= ST_HOLD;
                     end else begin
                        wtmr_q <= wtmr_q + CNT_W'(1);
                     end
`endif
                  end
               end
               ST_RELEASE: begin
                  if (timer_q == STEP_LAST) begin
                     timer_q <= '0;
                     rst_q   <= rst_q << 1;
                     stage_q <= stage_q + STG_W'(1);
                     if (stage_q == STG_LAST) begin
                        done_q  <= 1'b1;
                        state_q <= ST_RUN;
                     end
                  end else begin
                     timer_q <= timer_q + CNT_W'(1);
                  end
               end
               ST_RUN: ;
               default: state_q <= ST_POR;
            endcase
         end
      end
   end

   assign rst_o      = rst_q;
   assign done_o     = done_q;
   assign lost_cnt_o = lost_q;

endmodule

// File: tb/tb_rst_seq.sv
// Self-checking bench for rst_seq: directed scenarios plus randomized traffic against an elapsed-time model.
module tb_rst_seq;

   localparam int N_CH      = 4;
   localparam int T_POR     = 20;
   localparam int T_STEP    = 5;
   localparam int T_SOFT    = 8;
   localparam int RDY_FILT  = 3;
   localparam int T_RDY_TMO = 50;
`ifdef RST_SEQ_RDY_TMO_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   localparam int M_POR  = 0;
   localparam int M_HOLD = 1;
   localparam int M_WAIT = 2;
   localparam int M_SEQ  = 3;

   logic       clk = 1'b0;
   logic       rst_i;
   logic       soft_rst_i;
   logic       rdy_i;
   logic [3:0] rst_o;
   logic       done_o;
   logic [7:0] lost_cnt_o;
   logic       tmo_o;
   logic       rdy_err_o;

   int checks = 0;
   int errors = 0;

   rst_seq #(
      .N_CH      (N_CH),
      .CNT_W     (8),
      .T_POR     (T_POR),
      .T_STEP    (T_STEP),
      .T_SOFT    (T_SOFT),
      .RDY_FILT  (RDY_FILT),
      .T_RDY_TMO (T_RDY_TMO)
   ) dut (
      .clk        (clk),
      .rst_i      (rst_i),
      .soft_rst_i (soft_rst_i),
      .rdy_i      (rdy_i),
      .rst_o      (rst_o),
      .done_o     (done_o),
      .lost_cnt_o (lost_cnt_o),
      .tmo_o      (tmo_o),
      .rdy_err_o  (rdy_err_o)
   );

   always #5 clk = ~clk;

   // Reference model: phase plus elapsed edges; released channel count derived arithmetically.
   int m_mode, m_cnt, m_streak, m_seq, m_wait, m_lost;
   bit m_tmo, m_err;

   function automatic int released();
      int r;
      if (m_mode != M_SEQ) return 0;
      r = 1 + m_seq / T_STEP;
      if (r > N_CH) r = N_CH;
      return r;
   endfunction

   function automatic logic [3:0] exp_rst();
      logic [3:0] v;
      v = 4'hF;
      return v << released();
   endfunction

   function automatic logic exp_done();
      return released() == N_CH;
   endfunction

   task automatic enter_wait();
      m_mode = M_WAIT;
      m_streak = 0;
      m_wait = 0;
   endtask

   task automatic model_step(input logic r, input logic s, input logic d);
      m_tmo = 1'b0;
      if (!r) begin
         m_mode = M_POR; m_cnt = 0; m_streak = 0; m_seq = 0; m_wait = 0; m_lost = 0; m_err = 1'b0;
      end else if (s) begin
         m_mode = M_HOLD; m_cnt = 0;
      end else if (m_mode == M_SEQ && !d) begin
         enter_wait();
         if (m_lost < 255) m_lost++;
      end else begin
         case (m_mode)
            M_POR: begin
               m_cnt++;
               if (m_cnt == T_POR) enter_wait();
            end
            M_HOLD: begin
               m_cnt++;
               if (m_cnt == T_SOFT) enter_wait();
            end
            M_WAIT: begin
               m_streak = d ? m_streak + 1 : 0;
               if (m_streak == RDY_FILT) begin
                  m_mode = M_SEQ;
                  m_seq = 0;
               end else if (TMO_EN) begin
                  m_wait++;
                  if (m_wait == T_RDY_TMO) begin
                     m_tmo = 1'b1; m_err = 1'b1; m_mode = M_HOLD; m_cnt = 0;
                  end
               end
            end
            default: if (released() < N_CH) m_seq++;
         endcase
      end
   endtask

   task automatic tick(input logic r, input logic s, input logic d);
      rst_i = r;
      soft_rst_i = s;
      rdy_i = d;
      @(posedge clk);
      model_step(r, s, d);
      #1;
   endtask

   function automatic logic [3:0] release_mask(input int e, input int first);
      if (e >= first + 3 * T_STEP) return 4'h0;
      if (e >= first + 2 * T_STEP) return 4'h8;
      if (e >= first + T_STEP)     return 4'hC;
      if (e >= first)              return 4'hE;
      return 4'hF;
   endfunction

   task automatic test_reset();
      tick(0, 0, 1);
      tick(0, 0, 1);
      checks++; if (rst_o !== 4'hF) begin errors++; $display("FAIL reset_rst_o: got %h expected f", rst_o); end
      checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done_o); end
      checks++; if (lost_cnt_o !== 8'd0) begin errors++; $display("FAIL reset_lost: got %0d expected 0", lost_cnt_o); end
      checks++; if (tmo_o !== 1'b0 || rdy_err_o !== 1'b0) begin
         errors++; $display("FAIL reset_tmo: got tmo=%b err=%b expected 0/0", tmo_o, rdy_err_o);
      end
   endtask

   task automatic test_power_on();
      for (int e = 1; e <= 40; e++) begin
         tick(1, 0, 1);
         checks++; if (rst_o !== release_mask(e, 23)) begin
            errors++; $display("FAIL por_rst_o edge %0d: got %h expected %h", e, rst_o, release_mask(e, 23));
         end
         checks++; if (done_o !== (e >= 38)) begin
            errors++; $display("FAIL por_done edge %0d: got %b expected %b", e, done_o, e >= 38);
         end
      end
   endtask

   task automatic test_ready_loss();
      tick(1, 0, 0);
      checks++; if (rst_o !== 4'hF || done_o !== 1'b0) begin
         errors++; $display("FAIL loss_reassert: got rst=%h done=%b expected f/0", rst_o, done_o);
      end
      checks++; if (lost_cnt_o !== 8'd1) begin errors++; $display("FAIL loss_count: got %0d expected 1", lost_cnt_o); end
      for (int k = 1; k <= 20; k++) begin
         tick(1, 0, 1);
         checks++; if (rst_o !== release_mask(k, 3) || done_o !== (k >= 18)) begin
            errors++; $display("FAIL loss_recover +%0d: got rst=%h done=%b expected %h/%b",
                               k, rst_o, done_o, release_mask(k, 3), k >= 18);
         end
      end
   endtask

   task automatic test_reset_in_run();
      tick(0, 0, 1);
      checks++; if (rst_o !== 4'hF || done_o !== 1'b0 || lost_cnt_o !== 8'd0 || tmo_o !== 1'b0 || rdy_err_o !== 1'b0) begin
         errors++; $display("FAIL run_reset: got rst=%h done=%b lost=%0d expected f/0/0", rst_o, done_o, lost_cnt_o);
      end
      for (int e = 1; e <= 25; e++) begin
         tick(1, 0, 1);
         checks++; if (rst_o !== release_mask(e, 23)) begin
            errors++; $display("FAIL run_reset_por edge %0d: got %h expected %h", e, rst_o, release_mask(e, 23));
         end
      end
   endtask

   task automatic test_soft();
      tick(0, 0, 1);
      for (int e = 1; e <= 29; e++) tick(1, 0, 1);
      checks++; if (rst_o !== 4'hC) begin errors++; $display("FAIL soft_pre: got %h expected c", rst_o); end
      tick(1, 1, 1);
      checks++; if (rst_o !== 4'hF || done_o !== 1'b0) begin
         errors++; $display("FAIL soft_assert: got rst=%h done=%b expected f/0", rst_o, done_o);
      end
      for (int e = 31; e <= 45; e++) begin
         tick(1, 0, 1);
         checks++; if (rst_o !== release_mask(e, 41)) begin
            errors++; $display("FAIL soft_hold edge %0d: got %h expected %h", e, rst_o, release_mask(e, 41));
         end
      end
      checks++; if (lost_cnt_o !== 8'd0) begin errors++; $display("FAIL soft_lost: got %0d expected 0", lost_cnt_o); end
   endtask

   task automatic test_timeout();
      tick(0, 0, 0);
      for (int e = 1; e <= T_POR; e++) tick(1, 0, 0);
      for (int w = 1; w <= T_RDY_TMO; w++) begin
         tick(1, 0, 0);
         checks++; if (tmo_o !== (TMO_EN && w == T_RDY_TMO) || rdy_err_o !== (TMO_EN && w == T_RDY_TMO)) begin
            errors++; $display("FAIL tmo_wait %0d: got tmo=%b err=%b expected %b", w, tmo_o, rdy_err_o,
                               TMO_EN && w == T_RDY_TMO);
         end
      end
      for (int h = 1; h <= T_SOFT; h++) begin
         tick(1, 0, 0);
         checks++; if (tmo_o !== 1'b0 || rdy_err_o !== TMO_EN || rst_o !== 4'hF) begin
            errors++; $display("FAIL tmo_hold %0d: got tmo=%b err=%b rst=%h expected 0/%b/f", h, tmo_o, rdy_err_o,
                               rst_o, TMO_EN);
         end
      end
      for (int k = 1; k <= 3; k++) tick(1, 0, 1);
      checks++; if (rst_o !== 4'hE || rdy_err_o !== TMO_EN) begin
         errors++; $display("FAIL tmo_retry: got rst=%h err=%b expected e/%b", rst_o, rdy_err_o, TMO_EN);
      end
   endtask

   task automatic test_lost_saturation();
      tick(0, 0, 0);
      for (int e = 1; e <= T_POR; e++) tick(1, 0, 0);
      for (int i = 1; i <= 300; i++) begin
         for (int k = 0; k < RDY_FILT; k++) tick(1, 0, 1);
         tick(1, 0, 0);
         checks++; if (lost_cnt_o !== 8'((i > 255) ? 255 : i)) begin
            errors++; $display("FAIL lost_sat %0d: got %0d expected %0d", i, lost_cnt_o, (i > 255) ? 255 : i);
         end
      end
      tick(1, 1, 1);
      tick(1, 0, 1);
      checks++; if (lost_cnt_o !== 8'd255) begin errors++; $display("FAIL lost_soft: got %0d expected 255", lost_cnt_o); end
      tick(0, 0, 1);
      checks++; if (lost_cnt_o !== 8'd0) begin errors++; $display("FAIL lost_rst: got %0d expected 0", lost_cnt_o); end
   endtask

   task automatic test_random();
      logic [14:0] got, exp;
      logic r, s, d;
      tick(0, 0, 1);
      for (int n = 0; n < 3000; n++) begin
         r = ($urandom_range(0, 399) != 0);
         s = ($urandom_range(0, 59) == 0);
         d = ($urandom_range(0, 15) != 0);
         tick(r, s, d);
         got = {rst_o, done_o, lost_cnt_o, tmo_o, rdy_err_o};
         exp = {exp_rst(), exp_done(), 8'(m_lost), m_tmo, m_err};
         checks++; if (got !== exp) begin
            errors++; $display("FAIL random %0d: got {rst,done,lost,tmo,err}=%h expected %h", n, got, exp);
         end
      end
   endtask

   initial begin
      rst_i = 1'b0;
      soft_rst_i = 1'b0;
      rdy_i = 1'b0;
      test_reset();
      test_power_on();
      test_ready_loss();
      test_reset_in_run();
      test_soft();
      test_timeout();
      test_lost_saturation();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
